video_timing_gen: RTL

- Parametrised successor to the fixed-count arcade raster generator.
- Produces pixel counters, blanking, sync and blanked RGB from a pixel clock-enable on the system clock, rather than from a derived pixel clock.
- Timing, sync polarity and RGB width are set by parameters; runtime H/V screen-shift offsets are latched per frame.
- Sits between the game core (consumes HPOS/VPOS, supplies iRGB) and the video/rotate path.

---
 rtl/video_timing_pkg.sv | 20 ++
 rtl/vt_axis_counter.sv | 33 +++
 rtl/video_timing_gen.sv | 90 +++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// video_timing_pkg: default arcade raster timing and helpers shared by the timing generator.
package video_timing_pkg;
    localparam int DEF_H_ACTIVE = 288;
    localparam int DEF_H_FP     = 20;
    localparam int DEF_H_SYNC   = 32;
    localparam int DEF_H_BP     = 44;
    localparam int DEF_V_ACTIVE = 224;
    localparam int DEF_V_FP     = 11;
    localparam int DEF_V_SYNC   = 7;
    localparam int DEF_V_BP     = 21;

    function automatic int total(input int a, input int fp, input int s, input int bp);
        return a + fp + s + bp;
    endfunction

    // Callers truncate the result to a signed CNT_W+1 offset register.
    function automatic int clamp_off(input int off, input int lo, input int hi);
        return off < lo ? lo : off > hi ? hi : off;
    endfunction
endpackage

// File: rtl/vt_axis_counter.sv
// vt_axis_counter: one raster axis counter with wrap flag and undelayed blank/sync decode.
module vt_axis_counter #(
    parameter int TOTAL      = 384,
    parameter int ACTIVE     = 288,
    parameter int SYNC_START = 308,
    parameter int SYNC_LEN   = 32,
    parameter int CNT_W      = 9
) (
    input  logic               clk_sys,
    input  logic               rst_n,
    input  logic               en,
    input  logic signed [CNT_W:0] offset,
    output logic [CNT_W-1:0]   cnt,
    output logic               wrap,
    output logic               blank,
    output logic               sync
);
    int start;

    always_comb begin
        start = SYNC_START + int'(offset);
        wrap  = cnt == CNT_W'(TOTAL - 1);
        blank = int'(cnt) >= ACTIVE;
        sync  = int'(cnt) >= start && int'(cnt) < start + SYNC_LEN;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (en)
            cnt <= wrap ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: clock-enabled raster generator with per-frame sync shift and blanked RGB.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int RGB_W    = 12,
    parameter int OFF_W    = 4,
    parameter int CNT_W    = 9
) (
    input  logic                    clk_sys,
    input  logic                    rst_n,
    input  logic                    ce_pix,
    input  logic signed [OFF_W-1:0] h_off,
    input  logic signed [OFF_W-1:0] v_off,
    input  logic [RGB_W-1:0]        iRGB,
    output logic [CNT_W-1:0]        HPOS,
    output logic [CNT_W-1:0]        VPOS,
    output logic [RGB_W-1:0]        oRGB,
    output logic                    HBLK,
    output logic                    VBLK,
    output logic                    HSYN,
    output logic                    VSYN,
    output logic                    line_start,
    output logic                    frame_start,
    output logic [7:0]              frame_cnt
);
    localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    logic signed [CNT_W:0] ho, vo;
    logic h_wrap, h_blank, h_sync, v_wrap, v_blank, v_sync, frame_wrap;

    vt_axis_counter #(
        .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE), .SYNC_START(H_ACTIVE + H_FP),
        .SYNC_LEN(H_SYNC), .CNT_W(CNT_W)
    ) u_h (
        .clk_sys(clk_sys), .rst_n(rst_n), .en(ce_pix), .offset(ho),
        .cnt(HPOS), .wrap(h_wrap), .blank(h_blank), .sync(h_sync)
    );

    vt_axis_counter #(
        .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE), .SYNC_START(V_ACTIVE + V_FP),
        .SYNC_LEN(V_SYNC), .CNT_W(CNT_W)
    ) u_v (
        .clk_sys(clk_sys), .rst_n(rst_n), .en(ce_pix & h_wrap), .offset(vo),
        .cnt(VPOS), .wrap(v_wrap), .blank(v_blank), .sync(v_sync)
    );

    assign frame_wrap = ce_pix & h_wrap & v_wrap;

    // Offsets only change at the frame wrap so a sync pulse is never split mid-frame.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            ho          <= '0;
            vo          <= '0;
            frame_cnt   <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            HBLK        <= 1'b1;
            VBLK        <= 1'b1;
            HSYN        <= ~HS_POL;
            VSYN        <= ~VS_POL;
            oRGB        <= '0;
        end else begin
            line_start  <= ce_pix & h_wrap;
            frame_start <= frame_wrap;
            if (frame_wrap) begin
                ho        <= (CNT_W+1)'(clamp_off(int'(h_off), -H_FP, H_BP));
                vo        <= (CNT_W+1)'(clamp_off(int'(v_off), -V_FP, V_BP));
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (ce_pix) begin
                HBLK <= h_blank;
                VBLK <= v_blank;
                HSYN <= h_sync ? HS_POL : ~HS_POL;
                VSYN <= v_sync ? VS_POL : ~VS_POL;
                oRGB <= (h_blank | v_blank) ? '0 : iRGB;
            end
        end
    end
endmodule
